sorter_stream_mux: RTL

// N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake.

---
 rtl/sorter_stream_mux.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sorter_stream_mux.sv
// N-channel registered stream multiplexer with valid/ready handshake.
// MODE 0 picks the channel from sel; MODE 1 arbitrates round-robin over valid channels.
// One output register stage; xfer_cnt counts accepted input beats and wraps silently.
module sorter_stream_mux #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned MODE  = 0,
   parameter int unsigned CNTW  = 16,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNTW-1:0]      xfer_cnt
);

   logic [N-1:0]     grant;
   logic             space;
   logic             xfer;
   logic [SELW-1:0]  xfer_ch;
   logic [WIDTH-1:0] xfer_data;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [CNTW-1:0]  xfer_cnt_q, xfer_cnt_d;
   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

   // The output register can take a new beat when empty or draining this cycle.
   assign space = !out_valid_q || out_ready;

   // One-hot grant: direct select in MODE 0, rotating priority from rr_ptr in MODE 1.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      if (MODE == 0) begin
         if (32'(sel) < N) begin
            grant[sel] = 1'b1;
         end
      end else begin
         // First pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1.
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (i >= 32'(rr_ptr_q))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (i < 32'(rr_ptr_q))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   // Ready is held low throughout reset.
   assign in_ready = (rst_n && space) ? grant : '0;

   // Identify the accepted channel (at most one because grant is one-hot).
   always_comb begin
      xfer      = 1'b0;
      xfer_ch   = '0;
      xfer_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            xfer      = 1'b1;
            xfer_ch   = SELW'(i);
            xfer_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state for the output stage, counter and round-robin pointer.
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      xfer_cnt_d  = xfer_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = xfer_data;
         out_ch_d    = xfer_ch;
         out_valid_d = 1'b1;
         xfer_cnt_d  = xfer_cnt_q + 1'b1;
         if (MODE != 0) begin
            rr_ptr_d = (xfer_ch == SELW'(N - 1)) ? '0 : xfer_ch + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         xfer_cnt_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         xfer_cnt_q  <= xfer_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule
